// File: rtl/matrix_result_buffer_if.sv
// Purpose: bundles the result-capture and drain handshake signals of matrix_result_buffer.
// Latency: none; this is a wiring bundle only.
// Backpressure: o_rdy from the consumer; overruns on res_vld are reported on ovf, never stalled.
//
// Ports (signals):
//   res/res_vld             element strobe from the 2x2 multiplier (C00, C01, C10, C11 order)
//   o_data/o_idx/o_vld      element being drained, its index, and its valid flag
//   o_rdy                   consumer accept
//   o_last                  high with the C11 element
//   mat_done/busy/ovf       completion pulse, occupancy, sticky overrun flag
//   o_trace                 only when RESULT_TRACE_EN is defined: C00 + C11 of the presented bank
// Modports: master = the buffer itself, slave = the producer/consumer environment.

interface matrix_result_buffer_if #(
   parameter int W = 9
);
   logic [W-1:0] res;
   logic         res_vld;
   logic [W-1:0] o_data;
   logic [1:0]   o_idx;
   logic         o_vld;
   logic         o_rdy;
   logic         o_last;
   logic         mat_done;
   logic         busy;
   logic         ovf;
`ifdef RESULT_TRACE_EN
   logic [W:0]   o_trace;

   modport master (
      input  res, res_vld, o_rdy,
      output o_data, o_idx, o_vld, o_last, mat_done, busy, ovf, o_trace
   );
   modport slave (
      output res, res_vld, o_rdy,
      input  o_data, o_idx, o_vld, o_last, mat_done, busy, ovf, o_trace
   );
`else
   modport master (
      input  res, res_vld, o_rdy,
      output o_data, o_idx, o_vld, o_last, mat_done, busy, ovf
   );
   modport slave (
      output res, res_vld, o_rdy,
      input  o_data, o_idx, o_vld, o_last, mat_done, busy, ovf
   );
`endif
endinterface

// File: rtl/matrix_result_buffer.sv
// Purpose: ping-pong 2x4 result buffer behind the 2x2 matrix multiplier.
// Latency: o_vld and mat_done rise the cycle after the 4th element of a matrix is captured.
// Backpressure: o_rdy holds the presented element; a res_vld that finds no free bank is dropped and sets ovf.
//
// Ports:
//   clk  - system clock, rising edge
//   mr   - master reset, asynchronous, active-low; clears all state including bank contents
//   bus  - matrix_result_buffer_if.master (capture strobe, drain handshake, status flags)
// Optional feature macro: RESULT_TRACE_EN adds bus.o_trace = bank[rb][0] + bank[rb][3] while o_vld.

module matrix_result_buffer #(
   parameter int W = 9
) (
   input  logic                   clk,
   input  logic                   mr,
   matrix_result_buffer_if.master bus
);

   // Writer: FILL while the bank under wb has room, STALL while both banks await draining.
   typedef enum logic {
      WR_FILL  = 1'b0,
      WR_STALL = 1'b1
   } wr_state_e;

   // Reader: DRAIN while the bank under rb holds a complete matrix.
   typedef enum logic {
      RD_IDLE  = 1'b0,
      RD_DRAIN = 1'b1
   } rd_state_e;

   logic [W-1:0] bank_q [2][4];
   logic [W-1:0] bank_d [2][4];

   logic         wb_q, wb_d;
   logic [1:0]   wc_q, wc_d;
   logic         rb_q, rb_d;
   logic [1:0]   rc_q, rc_d;
   logic [1:0]   full_q, full_d;
   logic         ovf_q, ovf_d;
   logic         mat_done_q, mat_done_d;
   wr_state_e    wr_state_q, wr_state_d;
   rd_state_e    rd_state_q, rd_state_d;

   logic         rd_hs;
   logic         rd_done;
   logic         wr_bypass;
   logic         wr_accept;

   // ------------------------------------------------------------------
   // Next-state logic for both FSMs and the shared full flags
   // ------------------------------------------------------------------
   always_comb begin
      bank_d     = bank_q;
      wb_d       = wb_q;
      wc_d       = wc_q;
      rb_d       = rb_q;
      rc_d       = rc_q;
      full_d     = full_q;
      ovf_d      = ovf_q;
      mat_done_d = 1'b0;

      rd_hs     = (rd_state_q == RD_DRAIN) && bus.o_rdy;
      rd_done   = rd_hs && (rc_q == 2'd3);
      // A full write bank can still take the sample if its last element leaves
      // this very cycle; wc is necessarily 0 then, so the refill starts at C00.
      wr_bypass = rd_done && (rb_q == wb_q);
      wr_accept = bus.res_vld && ((wr_state_q == WR_FILL) || wr_bypass);

      // Reader side
      if (rd_hs) begin
         rc_d = rc_q + 2'd1;
         if (rc_q == 2'd3) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
         end
      end

      // Writer side; applied after the reader so a same-bank clear/set
      // resolves to "set", and a bypass refill leaves the flag cleared.
      if (wr_accept) begin
         bank_d[wb_q][wc_q] = bus.res;
         wc_d               = wc_q + 2'd1;
         if (wc_q == 2'd3) begin
            full_d[wb_q] = 1'b1;
            wb_d         = ~wb_q;
            mat_done_d   = 1'b1;
         end
      end else if (bus.res_vld) begin
         ovf_d = 1'b1;
      end

      // States track the flag of the bank each pointer will address next cycle.
      wr_state_d = full_d[wb_d] ? WR_STALL : WR_FILL;
      rd_state_d = full_d[rb_d] ? RD_DRAIN : RD_IDLE;
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge mr) begin
      if (!mr) begin
         for (int b = 0; b < 2; b++) begin
            for (int e = 0; e < 4; e++) begin
               bank_q[b][e] <= '0;
            end
         end
         wb_q       <= 1'b0;
         wc_q       <= 2'd0;
         rb_q       <= 1'b0;
         rc_q       <= 2'd0;
         full_q     <= 2'b00;
         ovf_q      <= 1'b0;
         mat_done_q <= 1'b0;
         wr_state_q <= WR_FILL;
         rd_state_q <= RD_IDLE;
      end else begin
         bank_q     <= bank_d;
         wb_q       <= wb_d;
         wc_q       <= wc_d;
         rb_q       <= rb_d;
         rc_q       <= rc_d;
         full_q     <= full_d;
         ovf_q      <= ovf_d;
         mat_done_q <= mat_done_d;
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs: all straight from registers, so they hold under o_rdy low
   // ------------------------------------------------------------------
   assign bus.o_vld    = (rd_state_q == RD_DRAIN);
   assign bus.o_data   = bank_q[rb_q][rc_q];
   assign bus.o_idx    = rc_q;
   assign bus.o_last   = (rd_state_q == RD_DRAIN) && (rc_q == 2'd3);
   assign bus.mat_done = mat_done_q;
   assign bus.busy     = full_q[0] | full_q[1] | (wc_q != 2'd0);
   assign bus.ovf      = ovf_q;

`ifdef RESULT_TRACE_EN
   assign bus.o_trace = (rd_state_q == RD_DRAIN)
                      ? ({1'b0, bank_q[rb_q][0]} + {1'b0, bank_q[rb_q][3]})
                      : '0;
`endif

endmodule

// File: tb/tb_matrix_result_buffer.sv
// Purpose: scoreboard bench for matrix_result_buffer (reset, single matrix, back-pressure,
// ping-pong streaming, overrun, free-on-drain bypass). Honours RESULT_TRACE_EN when defined.
module tb_matrix_result_buffer;

   localparam int W = 9;

   logic clk;
   logic mr;

   matrix_result_buffer_if #(.W(W)) bus ();

   matrix_result_buffer #(.W(W)) u_dut (
      .clk (clk),
      .mr  (mr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] data;
      logic [1:0]   idx;
`ifdef RESULT_TRACE_EN
      logic [W:0]   trace;
`endif
   } exp_t;

   exp_t sb[$];

   int n_vec     = 0;
   int n_miscmp  = 0;
   int n_done    = 0;
   int done_base = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push_mat(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
      logic [W-1:0] v [4];
      exp_t e;
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      for (int i = 0; i < 4; i++) begin
         e.data = v[i];
         e.idx  = 2'(i);
`ifdef RESULT_TRACE_EN
         e.trace = {1'b0, a} + {1'b0, d};
`endif
         sb.push_back(e);
      end
   endtask

   // Called at #1 after a rising edge; the sample is taken at the next edge.
   task automatic drive_elem(input logic [W-1:0] v);
      bus.res     = v;
      bus.res_vld = 1'b1;
      @(posedge clk);
      #1;
      bus.res_vld = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain(input int budget);
      int t;
      t = 0;
      while (sb.size() != 0 && t < budget) begin
         step(1);
         t++;
      end
      chk("drain_done", sb.size(), 0);
      step(2);
   endtask

   task automatic do_reset();
      mr = 1'b0;
      step(2);
      mr = 1'b1;
      step(1);
      sb.delete();
   endtask

   // Output monitor, sampling mid-cycle.
   always @(negedge clk) begin
      if (mr) begin
         if (bus.mat_done) n_done++;
         if (bus.o_vld && bus.o_rdy) begin
            if (sb.size() == 0) begin
               chk("spurious_out", sb.size(), 1);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("o_data", bus.o_data, e.data);
               chk("o_idx", bus.o_idx, e.idx);
               chk("o_last", bus.o_last, (e.idx == 2'd3));
`ifdef RESULT_TRACE_EN
               chk("o_trace", bus.o_trace, e.trace);
`endif
            end
         end
`ifdef RESULT_TRACE_EN
         if (!bus.o_vld) chk("o_trace_idle", bus.o_trace, 0);
`endif
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mr          = 1'b0;
      bus.res     = '0;
      bus.res_vld = 1'b0;
      bus.o_rdy   = 1'b0;

      // ---------------- reset state ----------------
      step(2);
      chk("rst_o_vld", bus.o_vld, 0);
      chk("rst_o_data", bus.o_data, 0);
      chk("rst_o_idx", bus.o_idx, 0);
      chk("rst_o_last", bus.o_last, 0);
      chk("rst_mat_done", bus.mat_done, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ovf", bus.ovf, 0);
      mr = 1'b1;
      step(1);

      // ---------------- single matrix, latency ----------------
      bus.o_rdy = 1'b1;
      done_base = n_done;
      push_mat(9'd5, 9'd12, 9'd33, 9'd441);
      drive_elem(9'd5);
      drive_elem(9'd12);
      drive_elem(9'd33);
      chk("busy_partial", bus.busy, 1);
      drive_elem(9'd441);
      chk("lat_mat_done", bus.mat_done, 1);
      chk("lat_o_vld", bus.o_vld, 1);
      chk("lat_first", bus.o_data, 5);
`ifdef RESULT_TRACE_EN
      chk("lat_trace", bus.o_trace, 446);
`endif
      step(1);
      chk("mat_done_pulse", bus.mat_done, 0);
      wait_drain(20);
      chk("single_done_cnt", n_done - done_base, 1);
      chk("single_busy", bus.busy, 0);

      // ---------------- back-pressure ----------------
      bus.o_rdy = 1'b0;
      push_mat(9'd5, 9'd12, 9'd33, 9'd441);
      drive_elem(9'd5);
      drive_elem(9'd12);
      drive_elem(9'd33);
      drive_elem(9'd441);
      for (int i = 0; i < 6; i++) begin
         chk("bp_vld", bus.o_vld, 1);
         chk("bp_data", bus.o_data, 5);
         chk("bp_idx", bus.o_idx, 0);
         step(1);
      end
      bus.o_rdy = 1'b1;
      wait_drain(20);

      // ---------------- ping-pong streaming ----------------
      done_base = n_done;
      push_mat(9'd1, 9'd2, 9'd3, 9'd4);
      push_mat(9'd10, 9'd11, 9'd12, 9'd13);
      push_mat(9'd101, 9'd102, 9'd103, 9'd104);
      push_mat(9'd301, 9'd302, 9'd303, 9'd510);
      drive_elem(9'd1);   drive_elem(9'd2);   drive_elem(9'd3);   drive_elem(9'd4);
      drive_elem(9'd10);  drive_elem(9'd11);  drive_elem(9'd12);  drive_elem(9'd13);
      drive_elem(9'd101); drive_elem(9'd102); drive_elem(9'd103); drive_elem(9'd104);
      drive_elem(9'd301); drive_elem(9'd302); drive_elem(9'd303); drive_elem(9'd510);
      wait_drain(30);
      chk("pp_done_cnt", n_done - done_base, 4);
      chk("pp_ovf", bus.ovf, 0);

      // ---------------- reset mid-stream ----------------
      bus.o_rdy = 1'b0;
      drive_elem(9'd77); drive_elem(9'd78); drive_elem(9'd79); drive_elem(9'd80);
      drive_elem(9'd81); drive_elem(9'd82);
      chk("pre_rst_vld", bus.o_vld, 1);
      mr = 1'b0;
      #1;
      chk("mid_rst_vld", bus.o_vld, 0);
      chk("mid_rst_data", bus.o_data, 0);
      chk("mid_rst_idx", bus.o_idx, 0);
      chk("mid_rst_last", bus.o_last, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_done", bus.mat_done, 0);
      sb.delete();
      step(2);
      mr = 1'b1;
      done_base = n_done;
      bus.o_rdy = 1'b1;
      step(4);
      chk("post_rst_done_cnt", n_done - done_base, 0);
      chk("post_rst_busy", bus.busy, 0);
      chk("post_rst_vld", bus.o_vld, 0);

      // ---------------- overrun ----------------
      bus.o_rdy = 1'b0;
      done_base = n_done;
      push_mat(9'd41, 9'd42, 9'd43, 9'd44);
      push_mat(9'd51, 9'd52, 9'd53, 9'd54);
      drive_elem(9'd41); drive_elem(9'd42); drive_elem(9'd43); drive_elem(9'd44);
      drive_elem(9'd51); drive_elem(9'd52); drive_elem(9'd53); drive_elem(9'd54);
      chk("ovr_before", bus.ovf, 0);
      drive_elem(9'd61);
      chk("ovr_first", bus.ovf, 1);
      drive_elem(9'd62); drive_elem(9'd63); drive_elem(9'd64);
      step(3);
      bus.o_rdy = 1'b1;
      wait_drain(30);
      chk("ovr_done_cnt", n_done - done_base, 2);
      chk("ovr_sticky", bus.ovf, 1);
      chk("ovr_busy", bus.busy, 0);
      do_reset();
      chk("ovr_cleared", bus.ovf, 0);

      // ---------------- free-on-drain bypass ----------------
      bus.o_rdy = 1'b0;
      push_mat(9'd20, 9'd21, 9'd22, 9'd23);
      push_mat(9'd30, 9'd31, 9'd32, 9'd33);
      push_mat(9'd7, 9'd8, 9'd9, 9'd10);
      drive_elem(9'd20); drive_elem(9'd21); drive_elem(9'd22); drive_elem(9'd23);
      drive_elem(9'd30); drive_elem(9'd31); drive_elem(9'd32); drive_elem(9'd33);
      chk("byp_full_vld", bus.o_vld, 1);
      bus.o_rdy = 1'b1;
      step(3);
      chk("byp_at_last", bus.o_last, 1);
      drive_elem(9'd7);
      chk("byp_ovf", bus.ovf, 0);
      chk("byp_busy", bus.busy, 1);
      drive_elem(9'd8); drive_elem(9'd9); drive_elem(9'd10);
      wait_drain(30);
      chk("byp_ovf_end", bus.ovf, 0);
      chk("byp_busy_end", bus.busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule

// File: doc/matrix_result_buffer.md
# matrix_result_buffer

Downstream stage of the 2x2 matrix multiplier. Captures the four 9-bit result elements (C00, C01, C10, C11) as the multiplier produces them, holds them in a ping-pong pair of 4-entry banks, and drains each completed matrix through a valid/ready handshake. While one matrix drains, the next one can be captured. Overruns are flagged rather than silently corrupting a bank.

## Interface
Parameters:
- W, 9, result element width; it matches the multiplier output.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- mr  input  1  master reset, asynchronous, active-low.
- res  input  W  result element from the multiplier.
- res_vld  input  1  one-cycle strobe; res is valid. Elements arrive in order C00, C01, C10, C11.
- o_data  output  W  element being presented.
- o_idx  output  2  index of o_data: 0=C00, 1=C01, 2=C10, 3=C11.
- o_vld  output  1  o_data/o_idx valid.
- o_rdy  input  1  consumer accepts when o_vld && o_rdy.
- o_last  output  1  high with o_vld when o_idx==3.
- mat_done  output  1  one-cycle pulse when a bank's 4th element is written.
- busy  output  1  any bank full or any partial capture in progress.
- ovf  output  1  sticky overrun flag; cleared only by mr.

## Operation
- Storage: bank[0..1][0..3], W bits each, plus state registers:
  - wb: write bank pointer.
  - wc[1:0]: write index.
  - rb: read bank pointer.
  - rc[1:0]: read index.
  - full[1:0]: per-bank full flags.
- Writer FSM:
  - FILL: entered when !full[wb].
  - STALL: entered when full[wb], i.e. both banks await draining.
  - Accept rule: a res_vld is accepted if full[wb]==0, or if the reader completes bank wb in the same cycle (free-on-drain bypass).
  - On accept: bank[wb][wc] <= res and wc <= wc+1. When wc==3, also set full[wb], toggle wb, and pulse mat_done.
  - On reject: the sample is dropped, ovf <= 1, and wc is unchanged.
- Reader FSM:
  - IDLE: entered when !full[rb].
  - DRAIN: entered when full[rb].
  - o_vld = full[rb]; o_data = bank[rb][rc]; o_idx = rc; o_last = o_vld && rc==3.
  - On handshake: rc <= rc+1. When rc==3, also clear full[rb] and toggle rb.
  - Output values are held stable while o_vld && !o_rdy.
- Simultaneous events:
  - A set of full[wb] and a clear of full[rb] in the same cycle act on different banks, and both take effect.
  - A bypass accept when wb==rb both clears and refills bank wb. Under bypass, the new element lands at index wc (0), and the flag remains cleared until that bank's 4th write.
- busy = full[0] | full[1] | (wc!=0).
- Wrap: all indices and pointers wrap modulo their width with no special case.

## Timing
- Reset (mr low, asynchronous):
  - wb, wc, rb, rc, full <= 0.
  - ovf, mat_done <= 0.
  - o_vld, o_last, busy = 0; o_idx = 0; o_data = 0 (bank contents cleared).
- Reset mid-capture or mid-drain discards all partial and pending data. There is no replay.
- Latency: when the 4th res_vld is accepted at edge N, mat_done and o_vld are high in the cycle after edge N. C00 is presented first.
- Throughput: one element per cycle in each direction. A full 4-element drain takes 4 cycles with o_rdy held high.
- Back-to-back matrices with res_vld every cycle and o_rdy high sustain indefinitely with no ovf.
- mat_done is a single-cycle pulse per completed bank. It is registered.

## Configuration
- RESULT_TRACE_EN defined:
  - Adds output port o_trace (W+1 bits) = bank[rb][0] + bank[rb][3], zero-extended sum.
  - o_trace is valid whenever o_vld is high and is 0 otherwise.
- RESULT_TRACE_EN undefined:
  - The port and adder are absent.
  - All other behaviour is identical.

## Test plan
- Reset/idle: assert mr low mid-stream -> all outputs 0 immediately, no mat_done after release, busy 0.
- Single matrix: res 5,12,33,441 strobed on consecutive cycles, o_rdy=1 -> mat_done one cycle after the 4th strobe; o_data 5,12,33,441 with o_idx 0..3; o_last only with 441; with RESULT_TRACE_EN, o_trace=446.
- Back-pressure: o_rdy=0 for 6 cycles after o_vld rises -> o_data=5, o_idx=0 held stable; drain resumes in order when o_rdy=1.
- Ping-pong: two matrices (1..4, 10..13) at one element per cycle, o_rdy=1 -> 8 ordered outputs, 2 mat_done pulses, ovf=0.
- Overrun: o_rdy=0, three matrices sent -> first two banks full, ovf=1 at the first element of the third matrix; after o_rdy=1, only matrices 1 and 2 drain; ovf stays 1 until mr.
- Bypass: both banks full; o_rdy=1 on the last element of bank rb in the same cycle as res_vld=7 -> 7 accepted at index 0 of that bank, ovf=0.
